// File: rtl/ring_counter_sequencer.sv
// One-hot T-state ring for the CPU controller: 6 or 10 T-states per instruction,
// with halt, single-step, restart, one-hot corruption recovery and retirement count.
module ring_counter_sequencer #(
    parameter int unsigned RING_W = 10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_ring_counter,
    input  logic              extended_fetch,
    input  logic              run,
    input  logic              step_req,
    input  logic              restart,
    output logic [RING_W-1:0] ring_counter,
    output logic              halted,
    output logic              instr_done,
    output logic              onehot_err,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [RING_W-1:0] T0 = RING_W'(1);

    logic [RING_W-1:0] ring_q, ring_d;
    logic              halted_q, halted_d;
    logic              instr_done_q, instr_done_d;
    logic              onehot_err_q, onehot_err_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;
    logic              step_q, step_d;

    logic ring_bad;
    logic advance_en;
    logic wrap;

    always_comb begin
        ring_bad      = ($countones(ring_q) != 1);
        advance_en    = run | (step_req & ~step_q);
        wrap          = (ring_q[5] & ~extended_fetch) | ring_q[RING_W-1];

        ring_d        = ring_q;
        halted_d      = halted_q;
        instr_done_d  = 1'b0;
        onehot_err_d  = onehot_err_q;
        instr_count_d = instr_count_q;
        step_d        = step_req;

        // Restart owns the ring, but a coincident corruption is still recorded.
        if (restart) begin
            ring_d       = T0;
            halted_d     = 1'b0;
            onehot_err_d = onehot_err_q | ring_bad;
        end else if (ring_bad) begin
            ring_d       = T0;
            onehot_err_d = 1'b1;
        end else if (halted_q || !enable_ring_counter) begin
            halted_d = 1'b1;
        end else if (advance_en) begin
            if (wrap) begin
                ring_d        = T0;
                instr_count_d = instr_count_q + CNT_W'(1);
                instr_done_d  = 1'b1;
            end else begin
                ring_d = ring_q << 1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring_q        <= T0;
            halted_q      <= 1'b0;
            instr_done_q  <= 1'b0;
            onehot_err_q  <= 1'b0;
            instr_count_q <= '0;
            step_q        <= 1'b0;
        end else begin
            ring_q        <= ring_d;
            halted_q      <= halted_d;
            instr_done_q  <= instr_done_d;
            onehot_err_q  <= onehot_err_d;
            instr_count_q <= instr_count_d;
            step_q        <= step_d;
        end
    end

    assign ring_counter = ring_q;
    assign halted       = halted_q;
    assign instr_done   = instr_done_q;
    assign onehot_err   = onehot_err_q;
    assign instr_count  = instr_count_q;

endmodule
